// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encodings and op-class helpers for the mul/div scheduler.
package muldiv_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MDOP_NONE  = 3'd0,
        MDOP_MUL   = 3'd1,
        MDOP_MULTU = 3'd2,
        MDOP_DIV   = 3'd3,
        MDOP_DIVU  = 3'd4,
        MDOP_MTHI  = 3'd5,
        MDOP_MTLO  = 3'd6,
        MDOP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_LAUNCH = 2'd1,
        MD_RUN    = 2'd2,
        MD_WB     = 2'd3
    } md_state_e;

    function automatic logic op_is_mul(input md_op_e op);
        return (op == MDOP_MUL) || (op == MDOP_MULTU);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode-side and unit-side signals of the mul/div scheduler; slave is the scheduler.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic            op_valid;
    md_op_e          op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            stall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] res_lo;
    logic            res_valid;
    logic            dz;
    logic            tmo;

    logic              mul_start;
    logic              div_start;
    logic              u_signed;
    logic [XLEN-1:0]   u_a;
    logic [XLEN-1:0]   u_b;
    logic              mul_busy;
    logic [2*XLEN-1:0] mul_z;
    logic              div_busy;
    logic [XLEN-1:0]   div_q;
    logic [XLEN-1:0]   div_r;

    modport slave (
        input  op_valid, op, rs_data, rt_data,
        input  mul_busy, mul_z, div_busy, div_q, div_r,
        output stall, hi, lo, res_lo, res_valid, dz, tmo,
        output mul_start, div_start, u_signed, u_a, u_b
    );

    modport master (
        output op_valid, op, rs_data, rt_data,
        output mul_busy, mul_z, div_busy, div_q, div_r,
        input  stall, hi, lo, res_lo, res_valid, dz, tmo,
        input  mul_start, div_start, u_signed, u_a, u_b
    );

endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO register pair: MTHI/MTLO writes from rs, captures from MULTU product or DIV/DIVU result.
module muldiv_hilo
    import muldiv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic              cap_mulu,
    input  logic              cap_div,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [2*XLEN-1:0] mul_z,
    input  logic [XLEN-1:0]   div_q,
    input  logic [XLEN-1:0]   div_r,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);

    // Writes from IDLE (MTxx) and RUN (capture) can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (wr_hi)         hi <= rs_data;
            else if (cap_mulu) hi <= mul_z[2*XLEN-1:XLEN];
            else if (cap_div)  hi <= div_r;

            if (wr_lo)         lo <= rs_data;
            else if (cap_mulu) lo <= mul_z[XLEN-1:0];
            else if (cap_div)  lo <= div_q;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div scheduler: launches the iterative units, stalls the PC until done, writes HI/LO or MUL result.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CW          = 7
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);

    md_state_e       state_q;
    md_state_e       state_d;
    md_op_e          op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic idle_op_c;
    logic launch_c;
    logic dz_c;
    logic mthi_c;
    logic mtlo_c;
    logic busy_sel_c;
    logic done_c;
    logic tmo_c;

    assign idle_op_c  = (state_q == MD_IDLE) && bus.op_valid;
    assign launch_c   = idle_op_c && (op_is_mul(bus.op) || (op_is_div(bus.op) && (bus.rt_data != '0)));
    assign dz_c       = idle_op_c && op_is_div(bus.op) && (bus.rt_data == '0);
    assign mthi_c     = idle_op_c && (bus.op == MDOP_MTHI);
    assign mtlo_c     = idle_op_c && (bus.op == MDOP_MTLO);
    assign busy_sel_c = op_is_mul(op_q) ? bus.mul_busy : bus.div_busy;
    // The unit raises busy the cycle after start, so counter 0 cannot mean done.
    assign done_c     = (state_q == MD_RUN) && !busy_sel_c && (cnt_q != '0);
    assign tmo_c      = (state_q == MD_RUN) && !done_c && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Stall is combinational so the issuing cycle already holds the PC.
    assign bus.stall  = launch_c || (state_q == MD_LAUNCH) || (state_q == MD_RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE:   if (launch_c) state_d = MD_LAUNCH;
            MD_LAUNCH: state_d = MD_RUN;
            MD_RUN: begin
                if (done_c)     state_d = MD_WB;
                else if (tmo_c) state_d = MD_IDLE;
            end
            MD_WB:     state_d = MD_IDLE;
            default:   state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MD_IDLE;
            op_q          <= MDOP_NONE;
            cnt_q         <= '0;
            bus.u_a       <= '0;
            bus.u_b       <= '0;
            bus.u_signed  <= 1'b0;
            bus.res_lo    <= '0;
            bus.res_valid <= 1'b0;
            bus.dz        <= 1'b0;
            bus.tmo       <= 1'b0;
            bus.mul_start <= 1'b0;
            bus.div_start <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.mul_start <= launch_c && op_is_mul(bus.op);
            bus.div_start <= launch_c && op_is_div(bus.op);
            bus.dz        <= dz_c;
            bus.tmo       <= tmo_c;
            bus.res_valid <= done_c && (op_q == MDOP_MUL);

            if (launch_c) begin
                bus.u_a      <= bus.rs_data;
                bus.u_b      <= bus.rt_data;
                bus.u_signed <= (bus.op == MDOP_MUL) || (bus.op == MDOP_DIV);
                op_q         <= bus.op;
            end

            if (state_q == MD_LAUNCH)  cnt_q <= '0;
            else if (state_q == MD_RUN) cnt_q <= cnt_q + CW'(1);

            if (done_c && (op_q == MDOP_MUL)) bus.res_lo <= bus.mul_z[XLEN-1:0];
        end
    end

    muldiv_hilo u_hilo (
        .clk      (clk),
        .rst      (rst),
        .wr_hi    (mthi_c),
        .wr_lo    (mtlo_c),
        .cap_mulu (done_c && (op_q == MDOP_MULTU)),
        .cap_div  (done_c && op_is_div(op_q)),
        .rs_data  (bus.rs_data),
        .mul_z    (bus.mul_z),
        .div_q    (bus.div_q),
        .div_r    (bus.div_r),
        .hi       (hi_q),
        .lo       (lo_q)
    );

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural multiplier/divider models and a result scoreboard.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int TMO     = 64;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 6;

    typedef struct {
        logic        is_mul;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.TIMEOUT_CYC(TMO), .CW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural units: busy from the cycle after start for a fixed latency.
    int          mul_left = 0;
    int          div_left = 0;
    logic        force_div_busy = 1'b0;
    logic [63:0] mz = '0;
    logic [31:0] dq = '0;
    logic [31:0] dr = '0;

    assign bus.mul_busy = (mul_left != 0);
    assign bus.div_busy = force_div_busy || (div_left != 0);
    assign bus.mul_z    = mz;
    assign bus.div_q    = dq;
    assign bus.div_r    = dr;

    always @(posedge clk) begin
        if (rst) begin
            mul_left <= 0;
            div_left <= 0;
        end else begin
            if (bus.mul_start) begin
                mul_left <= MUL_LAT;
                if (bus.u_signed)
                    mz <= $signed({{32{bus.u_a[31]}}, bus.u_a}) * $signed({{32{bus.u_b[31]}}, bus.u_b});
                else
                    mz <= {32'b0, bus.u_a} * {32'b0, bus.u_b};
            end else if (mul_left > 0) begin
                mul_left <= mul_left - 1;
            end
            if (bus.div_start) begin
                div_left <= DIV_LAT;
                if (bus.u_b != 0) begin
                    if (bus.u_signed) begin
                        dq <= $signed(bus.u_a) / $signed(bus.u_b);
                        dr <= $signed(bus.u_a) % $signed(bus.u_b);
                    end else begin
                        dq <= bus.u_a / bus.u_b;
                        dr <= bus.u_a % bus.u_b;
                    end
                end
            end else if (div_left > 0) begin
                div_left <= div_left - 1;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op = MDOP_NONE;
        bus.rs_data = '0;
        bus.rt_data = '0;
        step;
        step;
        #1;
        n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h, want 0/0", bus.hi, bus.lo); end
        n_checks++; if (bus.u_a !== 32'h0 || bus.u_b !== 32'h0 || bus.res_lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got u_a=%h u_b=%h res_lo=%h, want 0", bus.u_a, bus.u_b, bus.res_lo); end
        n_checks++; if ({bus.stall, bus.mul_start, bus.div_start, bus.res_valid, bus.dz, bus.tmo} !== 6'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b, want 000000",
                {bus.stall, bus.mul_start, bus.div_start, bus.res_valid, bus.dz, bus.tmo}); end
        n_checks++; if (dut.state_q !== MD_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d, want %0d", dut.state_q, MD_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_mthi_mtlo;
        step;
        bus.op_valid = 1'b1; bus.op = MDOP_MTHI; bus.rs_data = 32'h1234; #1;
        n_checks++; if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL mthi_stall: got %b, want 0", bus.stall); end
        step;
        bus.op_valid = 1'b0; bus.op = MDOP_NONE; #1;
        n_checks++; if (bus.hi !== 32'h1234 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL mthi_hi: got hi=%h stall=%b, want 00001234/0", bus.hi, bus.stall); end
        step;
        bus.op_valid = 1'b1; bus.op = MDOP_MTLO; bus.rs_data = 32'hBEEF; #1;
        n_checks++; if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_stall: got %b, want 0", bus.stall); end
        step;
        bus.op_valid = 1'b0; bus.op = MDOP_NONE; #1;
        n_checks++; if (bus.lo !== 32'hBEEF || bus.hi !== 32'h1234) begin
            n_fail++; $display("FAIL mtlo_lo: got hi=%h lo=%h, want 00001234/0000beef", bus.hi, bus.lo); end
    endtask

    // Issue one unit op, hold it on decode while stalled, then check WB and HI/LO.
    task automatic do_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input string name);
        exp_t e;
        int   waited;
        logic is_mul;
        is_mul = (op == MDOP_MUL) || (op == MDOP_MULTU);
        step;
        bus.op_valid = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b; #1;
        n_checks++; if (bus.stall !== 1'b1 || bus.mul_start !== 1'b0 || bus.div_start !== 1'b0) begin
            n_fail++; $display("FAIL %s_issue: got stall=%b ms=%b ds=%b, want 1/0/0",
                name, bus.stall, bus.mul_start, bus.div_start); end
        step;
        #1;
        n_checks++; if (bus.mul_start !== is_mul || bus.div_start !== !is_mul
                         || bus.u_signed !== sgn || bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL %s_launch: got ms=%b ds=%b sgn=%b stall=%b, want %b/%b/%b/1",
                name, bus.mul_start, bus.div_start, bus.u_signed, bus.stall, is_mul, !is_mul, sgn); end
        bus.rs_data = 32'hDEAD_BEEF;
        bus.rt_data = 32'h0;
        waited = 0;
        while (bus.stall === 1'b1 && waited < 100) begin
            step;
            #1;
            waited++;
        end
        n_checks++; if (waited >= 100 || dut.state_q !== MD_WB) begin
            n_fail++; $display("FAIL %s_wb: got state=%0d after %0d cycles, want WB", name, dut.state_q, waited); end
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL %s_scoreboard: got empty queue, want one entry", name);
        end else begin
            e = sb.pop_front();
            n_checks++; if (bus.res_valid !== e.is_mul) begin
                n_fail++; $display("FAIL %s_res_valid: got %b, want %b", name, bus.res_valid, e.is_mul); end
            if (e.is_mul) begin
                n_checks++; if (bus.res_lo !== e.res) begin
                    n_fail++; $display("FAIL %s_res_lo: got %h, want %h", name, bus.res_lo, e.res); end
            end
            step;
            bus.op_valid = 1'b0; bus.op = MDOP_NONE; #1;
            n_checks++; if (bus.hi !== e.hi || bus.lo !== e.lo || bus.res_valid !== 1'b0 || bus.stall !== 1'b0) begin
                n_fail++; $display("FAIL %s_hilo: got hi=%h lo=%h rv=%b stall=%b, want %h/%h/0/0",
                    name, bus.hi, bus.lo, bus.res_valid, bus.stall, e.hi, e.lo); end
        end
    endtask

    task automatic test_multu;
        sb.push_back('{is_mul: 1'b0, hi: 32'h0000_0001, lo: 32'hFFFF_FFFE, res: 32'h0});
        do_md(MDOP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, "multu");
    endtask

    task automatic test_mul;
        sb.push_back('{is_mul: 1'b1, hi: 32'h0000_0001, lo: 32'hFFFF_FFFE, res: 32'hFFFF_FFF1});
        do_md(MDOP_MUL, 32'hFFFF_FFFD, 32'h5, 1'b1, "mul");
    endtask

    task automatic test_div;
        sb.push_back('{is_mul: 1'b0, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, res: 32'h0});
        do_md(MDOP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, "div");
    endtask

    task automatic test_div_zero;
        step;
        bus.op_valid = 1'b1; bus.op = MDOP_DIVU; bus.rs_data = 32'h7; bus.rt_data = 32'h0; #1;
        n_checks++; if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL dz_stall: got %b, want 0", bus.stall); end
        step;
        bus.op_valid = 1'b0; bus.op = MDOP_NONE; #1;
        n_checks++; if (bus.dz !== 1'b1 || bus.div_start !== 1'b0 || dut.state_q !== MD_IDLE) begin
            n_fail++; $display("FAIL dz_pulse: got dz=%b ds=%b state=%0d, want 1/0/IDLE",
                bus.dz, bus.div_start, dut.state_q); end
        step;
        #1;
        n_checks++; if (bus.dz !== 1'b0 || bus.div_start !== 1'b0 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL dz_after: got dz=%b ds=%b hi=%h lo=%h, want 0/0/ffffffff/fffffffd",
                bus.dz, bus.div_start, bus.hi, bus.lo); end
    endtask

    task automatic test_timeout;
        int   run_cnt;
        int   cyc;
        logic seen;
        force_div_busy = 1'b1;
        step;
        bus.op_valid = 1'b1; bus.op = MDOP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd3;
        step;
        bus.op_valid = 1'b0; bus.op = MDOP_NONE;
        run_cnt = 0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 200) begin
            step;
            #1;
            cyc++;
            if (dut.state_q == MD_RUN) run_cnt++;
            if (bus.tmo === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin
            n_fail++; $display("FAIL tmo_pulse: got none in %0d cycles, want one", cyc); end
        n_checks++; if (run_cnt != TMO) begin
            n_fail++; $display("FAIL tmo_run_cycles: got %0d, want %0d", run_cnt, TMO); end
        n_checks++; if (bus.stall !== 1'b0 || dut.state_q !== MD_IDLE || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL tmo_state: got stall=%b state=%0d hi=%h lo=%h, want 0/IDLE/ffffffff/fffffffd",
                bus.stall, dut.state_q, bus.hi, bus.lo); end
        step;
        #1;
        n_checks++; if (bus.tmo !== 1'b0) begin
            n_fail++; $display("FAIL tmo_width: got %b, want 0", bus.tmo); end
        force_div_busy = 1'b0;
    endtask

    task automatic test_rst_mid_run;
        step;
        bus.op_valid = 1'b1; bus.op = MDOP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        step;
        step;
        step;
        #1;
        n_checks++; if (dut.state_q !== MD_RUN) begin
            n_fail++; $display("FAIL rst_pre_state: got %0d, want RUN", dut.state_q); end
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op = MDOP_NONE;
        step;
        #1;
        n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.stall !== 1'b0 || dut.state_q !== MD_IDLE) begin
            n_fail++; $display("FAIL rst_mid: got hi=%h lo=%h stall=%b state=%0d, want 0/0/0/IDLE",
                bus.hi, bus.lo, bus.stall, dut.state_q); end
        rst = 1'b0;
        sb.push_back('{is_mul: 1'b0, hi: 32'h0000_0001, lo: 32'h0000_0000, res: 32'h0});
        do_md(MDOP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, "multu_after_rst");
    endtask

    initial begin
        test_reset;
        test_mthi_mtlo;
        test_multu;
        test_mul;
        test_div;
        test_div_zero;
        test_timeout;
        test_rst_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
